// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access controller.
// Latency: none (types, constants and a pure helper function).
// Backpressure: none.
package mem_access_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 128;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4,
    DONE = 3'd5
  } state_t;

  // True when a request must be rejected: bad size, misalignment, or the
  // containing word reaching past the end of memory (33-bit, no wrap).
  function automatic logic access_illegal(input logic [1:0] size,
                                          input logic [31:0] addr,
                                          input int unsigned mem_bytes);
    logic [32:0] last_byte;
    logic        bad;
    last_byte = {1'b0, addr[31:2], 2'b00} + 33'd3;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if (last_byte >= 33'(mem_bytes)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none.
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] new_data,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Offset 0 is the most significant lane of the memory word.
  always_comb begin
    lane_b   = 8'h00;
    lane_h   = offset[1] ? word[15:0] : word[31:16];
    load_val = word;
    merged   = word;
    case (offset)
      2'd0:    lane_b = word[31:24];
      2'd1:    lane_b = word[23:16];
      2'd2:    lane_b = word[15:8];
      default: lane_b = word[7:0];
    endcase
    case (size)
      SZ_BYTE: begin
        load_val = {{24{is_signed & lane_b[7]}}, lane_b};
        case (offset)
          2'd0:    merged[31:24] = new_data[7:0];
          2'd1:    merged[23:16] = new_data[7:0];
          2'd2:    merged[15:8]  = new_data[7:0];
          default: merged[7:0]   = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        load_val = {{16{is_signed & lane_h[15]}}, lane_h};
        if (offset[1]) merged[15:0]  = new_data[15:0];
        else           merged[31:16] = new_data[15:0];
      end
      default: begin
        load_val = word;
        merged   = new_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: one load/store at a time, sub-word stores as read-modify-write.
// Latency accept->resp_valid: load 3, word store 2, sub-word store 4, error 2 cycles.
// Backpressure: req_ready high only in IDLE; memory has no stall, responses are never held off.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRd,
  output logic        MemWr,
  output logic [31:0] Addr,
  output logic [31:0] W_data,
  input  logic [31:0] R_data
);

  state_t      state;
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  offset_q;
  logic [31:0] wdata_q;
  logic [31:0] load_val;
  logic [31:0] merged;

  byte_lane_unit u_lane (
    .word      (R_data),
    .offset    (offset_q),
    .size      (size_q),
    .is_signed (signed_q),
    .new_data  (wdata_q),
    .load_val  (load_val),
    .merged    (merged)
  );

  // Single-process FSM; every output is a register set on entry to the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      MemRd      <= 1'b0;
      MemWr      <= 1'b0;
      Addr       <= 32'h0;
      W_data     <= 32'h0;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= SZ_BYTE;
      offset_q   <= 2'b00;
      wdata_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            signed_q  <= req_signed;
            size_q    <= req_size;
            offset_q  <= req_addr[1:0];
            wdata_q   <= req_wdata;
            Addr      <= {req_addr[31:2], 2'b00};
            req_ready <= 1'b0;
            if (access_illegal(req_size, req_addr, MEM_BYTES)) begin
              state <= ERR;
            end else if (req_we && req_size == SZ_WORD) begin
              W_data <= req_wdata;
              MemWr  <= 1'b1;
              state  <= WR;
            end else begin
              MemRd <= 1'b1;
              state <= RD;
            end
          end
        end
        RD: begin
          MemRd <= 1'b0;
          state <= CAP;
        end
        CAP: begin
          // R_data now holds the word read in the previous cycle.
          if (we_q) begin
            W_data <= merged;
            MemWr  <= 1'b1;
            state  <= WR;
          end else begin
            resp_rdata <= load_val;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        WR: begin
          MemWr      <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        ERR: begin
          resp_rdata <= 32'h0;
          resp_err   <= 1'b1;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          MemRd      <= 1'b0;
          MemWr      <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: 128-byte big-endian memory plus byte-array reference model.
// Directed plan items, reset cases, then randomized requests.
// Each request is driven until resp_valid, with a bounded wait.
module tb_mem_access_ctrl;

  localparam int MB = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] W_data;
  logic [31:0] R_data;

  int checks = 0;
  int passed = 0;

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          rv_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] rd_addr = 32'h0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_word = 32'h0;
  logic [31:0] last_rdata = 32'h0;

  logic [7:0] mem     [0:MB-1];
  logic [7:0] ref_mem [0:MB-1];

  mem_access_ctrl #(.MEM_BYTES(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .MemRd      (MemRd),
    .MemWr      (MemWr),
    .Addr       (Addr),
    .W_data     (W_data),
    .R_data     (R_data)
  );

  always #5 clk = ~clk;

  // Memory: registered read on the MemRd edge, write on the MemWr edge.
  always @(posedge clk) begin
    if (MemRd && Addr < 32'(MB))
      R_data <= {mem[Addr[6:0]], mem[Addr[6:0] + 7'd1], mem[Addr[6:0] + 7'd2], mem[Addr[6:0] + 7'd3]};
    if (MemWr && Addr < 32'(MB)) begin
      mem[Addr[6:0]]         <= W_data[31:24];
      mem[Addr[6:0] + 7'd1]  <= W_data[23:16];
      mem[Addr[6:0] + 7'd2]  <= W_data[15:8];
      mem[Addr[6:0] + 7'd3]  <= W_data[7:0];
    end
  end

  // Strobe and response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (MemRd) begin rd_cnt++; rd_addr = Addr; end
    if (MemWr) begin wr_cnt++; wr_addr = Addr; wr_word = W_data; end
    if (MemRd && MemWr) both_cnt++;
    if (resp_valid) rv_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a + i]     = 8'(w >> (8 * (3 - i)));
      ref_mem[a + i] = 8'(w >> (8 * (3 - i)));
    end
  endtask

  // Issue one request, predict its outcome from the byte-array model, and check it.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
    int          n;
    int          idx;
    int          cyc;
    int          exp_lat;
    int          exp_rds;
    int          exp_wrs;
    bit          seen;
    bit          exp_err;
    longint      v;
    logic [31:0] aa;
    logic [31:0] exp_rd;
    logic [31:0] exp_w;

    n   = 1 << sz;
    aa  = {a[31:2], 2'b00};
    idx = int'(a[6:0]);
    exp_err = (sz == 2'b11) || ((a % n) != 0) || (longint'(aa) + 3 >= longint'(MB));
    exp_rd = 32'h0; exp_w = 32'h0; exp_lat = 2; exp_rds = 0; exp_wrs = 0;
    if (!exp_err) begin
      if (!we) begin
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[idx + i]);
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        exp_rd  = v[31:0];
        exp_lat = 3;
        exp_rds = 1;
      end else begin
        for (int i = 0; i < n; i++) ref_mem[idx + i] = 8'(wd >> (8 * (n - 1 - i)));
        exp_w   = {ref_mem[aa[6:0]], ref_mem[aa[6:0] + 7'd1], ref_mem[aa[6:0] + 7'd2], ref_mem[aa[6:0] + 7'd3]};
        exp_wrs = 1;
        exp_rds = (n < 4) ? 1 : 0;
        exp_lat = (n < 4) ? 4 : 2;
      end
    end

    @(negedge clk);
    rd_cnt = 0; wr_cnt = 0; rv_cnt = 0; both_cnt = 0;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Keep garbage on the request bus while busy; it must be ignored.
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    cyc = 0; seen = 0;
    while (!seen && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) seen = 1;
    end
    last_rdata = resp_rdata;
    check({tag, ".latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
    check({tag, ".rdata"}, resp_rdata, exp_rd);
    check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    check({tag, ".rv_cnt"}, 32'(rv_cnt), 32'd1);
    check({tag, ".rd_cnt"}, 32'(rd_cnt), 32'(exp_rds));
    check({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(exp_wrs));
    check({tag, ".both"}, 32'(both_cnt), 32'd0);
    if (exp_rds != 0) check({tag, ".rd_addr"}, rd_addr, aa);
    if (exp_wrs != 0) begin
      check({tag, ".wr_addr"}, wr_addr, aa);
      check({tag, ".wr_word"}, wr_word, exp_w);
    end
  endtask

  initial begin
    for (int i = 0; i < MB; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'h0);
    check("rst.MemRd", 32'(MemRd), 32'd0);
    check("rst.MemWr", 32'(MemWr), 32'd0);
    check("rst.Addr", Addr, 32'h0);
    check("rst.W_data", W_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word load and response hold
    set_word(32'h40, 32'h11223344);
    do_req("lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("lw40.lit", last_rdata, 32'h11223344);
    repeat (2) @(negedge clk);
    check("lw40.hold", resp_rdata, 32'h11223344);

    // Byte loads with sign/zero extension
    mem[8'h41] = 8'h9A; ref_mem[8'h41] = 8'h9A;
    do_req("lb41", 1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
    check("lb41.lit", last_rdata, 32'hFFFFFF9A);
    do_req("lbu41", 1'b0, 2'b00, 1'b0, 32'h41, 32'h0);
    check("lbu41.lit", last_rdata, 32'h0000009A);

    // Signed halfword load, low lane
    set_word(32'h40, 32'h1122F344);
    do_req("lh42", 1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
    check("lh42.lit", last_rdata, 32'hFFFFF344);

    // Sub-word stores as read-modify-write
    set_word(32'h40, 32'h11223344);
    do_req("sh42", 1'b1, 2'b01, 1'b0, 32'h42, 32'hDEADBEEF);
    check("sh42.wlit", wr_word, 32'h1122BEEF);
    do_req("lw40b", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("lw40b.lit", last_rdata, 32'h1122BEEF);
    do_req("sb40", 1'b1, 2'b00, 1'b0, 32'h40, 32'h000000AB);
    do_req("lw40c", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("lw40c.lit", last_rdata, 32'hAB22BEEF);

    // Errors: misaligned, illegal size, out of range
    do_req("lw42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
    do_req("sh41", 1'b1, 2'b01, 1'b0, 32'h41, 32'h5555);
    do_req("sz11", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    do_req("lw7c", 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0);
    do_req("lw80", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    do_req("sw7c", 1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D);
    do_req("lwtop", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);

    // Reset during the RD cycle of a load, with a competing request held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    check("mid.MemRd_before", 32'(MemRd), 32'd1);
    rst = 1'b1;
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    rd_cnt = 0; wr_cnt = 0; rv_cnt = 0;
    check("mid.MemRd_after", 32'(MemRd), 32'd0);
    check("mid.ready", 32'(req_ready), 32'd1);
    check("mid.resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid.no_resp", 32'(rv_cnt), 32'd0);
    check("mid.no_write", 32'(wr_cnt), 32'd0);
    check("mid.no_read", 32'(rd_cnt), 32'd0);
    do_req("mid.lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    // Randomized mix, including out-of-range and illegal requests
    for (int k = 0; k < 60; k++) begin
      do_req($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 140)), $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the multicycle CPU's data-memory port. It accepts one load/store request at a time from the datapath and drives the word-wide, big-endian, byte-addressed Memory through MemRd, MemWr, Addr, W_data and R_data. It performs byte, halfword and word accesses, and handles sub-word stores as read-modify-write. It sign- or zero-extends loads and flags misaligned or out-of-range addresses without touching memory.

Parameters:
MEM_BYTES, 128, memory size in bytes; any access with aligned_addr+3 >= MEM_BYTES is an error.

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted on posedge when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for byte/half
resp_valid  out  1  one-cycle pulse: operation complete
resp_rdata  out  32  load result (0 for stores and errors), held until next resp_valid
resp_err  out  1  qualified by resp_valid: misaligned, illegal size or out of range
MemRd  out  1  memory read strobe
MemWr  out  1  memory write strobe
Addr  out  32  memory address; always word-aligned {a[31:2],2'b00}
W_data  out  32  memory write word
R_data  in  32  memory read word, updated on the posedge where MemRd=1

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, MemRd=0, MemWr=0, Addr=0, W_data=0.
- On acceptance, latch we, size, signed, addr and wdata. Ignore req_* at all other times.
- Outputs are Moore outputs decoded from the state register. MemRd and MemWr are never high together.
- Memory read latency: R_data is valid in the cycle after the MemRd cycle.
- States and sequences:
  - IDLE: on accept, go to ERR if the request is illegal, RD if it is a load or sub-word store, WR if it is a word store.
  - RD: MemRd=1 for exactly one cycle, then go to CAP.
  - CAP: sample R_data.
    - Load: extract the lane and extend it into resp_rdata, then go to DONE.
    - Sub-word store: merge the new lane into the word, hold it in W_data, then go to WR.
  - WR: MemWr=1 for exactly one cycle; W_data = full word or merged word. Then go to DONE.
  - ERR: no memory strobe; set resp_err=1 and resp_rdata=0, then go to DONE.
  - DONE: resp_valid=1 for one cycle, then go to IDLE.
- Latency from the acceptance edge to the resp_valid cycle:
  - load: 3 cycles
  - word store: 2 cycles
  - sub-word store: 4 cycles
  - error: 2 cycles
- Big-endian lanes:
  - byte offset 0 is R_data[31:24], offset 3 is R_data[7:0]
  - half offset 0 is [31:16], offset 2 is [15:0]
- Store lanes: byte stores use req_wdata[7:0]; half stores use req_wdata[15:0]. All other bytes of the read word are preserved.
- Errors:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - {addr[31:2],2'b00}+3 >= MEM_BYTES, computed on 33 bits with no wrap
- rst mid-operation: the next edge forces IDLE with all strobes low. The pending operation is dropped with no resp_valid, and memory contents are unspecified only if rst hits during WR.
- rst dominates a simultaneous req_valid.

Decomposition:
- Package mem_access_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state encoding IDLE/RD/CAP/WR/ERR/DONE
  - MEM_BYTES default
- One combinational sub-module, byte_lane_unit. Inputs: word, offset, size, signed, new data. Outputs: extracted/extended load value and merged store word.
- The FSM and registers live in mem_access_ctrl.

Test Plan:
- lw at 0x40 with bytes 0x11,0x22,0x33,0x44 at 0x40..0x43 -> MemRd high exactly one cycle with Addr=0x40; resp_valid 3 cycles after accept; resp_rdata=0x11223344; resp_err=0.
- Byte 0x9A at 0x41: lb signed at 0x41 -> 0xFFFFFF9A; lbu -> 0x0000009A. lh signed at 0x42 with word 0x1122F344 -> 0xFFFFF344.
- sh at 0x42 with wdata 0xDEADBEEF over 0x11223344 -> one MemRd, then one MemWr with W_data=0x1122BEEF and Addr=0x40; resp_valid at cycle 4. A following lw returns 0x1122BEEF. sb at 0x40 with 0xAB -> 0xAB22BEEF.
- lw 0x42, sh 0x41, size 11 -> resp_err=1 at cycle 2, resp_rdata=0, MemRd and MemWr never asserted.
- Range with MEM_BYTES=128: lw 0x7C succeeds; lw 0x80 -> resp_err=1, no strobes.
- rst high in the RD cycle of a load -> MemRd=0 after the edge, req_ready=1, no resp_valid. A new lw then completes normally.
